// File: rtl/as_edge_detect_multi.sv
// -----------------------------------------------------------------------------
// as_edge_detect_multi
//
// Multi-channel asynchronous edge detector. Each of CHANNELS slow asynchronous
// inputs (bus phase clocks, RDY, IRQ lines, ...) is brought into the fast clk
// domain through a SYNC_STAGES-deep synchroniser. Each channel can then report
// rising, falling or both edges, selected at run time. Detected edges appear as
// a registered one-cycle pulse and also set a sticky event flag that holds
// until it is cleared.
//
// Optional build macro:
//   AS_EDGE_GLITCH_FILTER_EN - adds a per-channel stability counter between the
//   synchroniser and the edge logic. A level change is accepted only after it
//   has been stable for FILT_CYCLES cycles. This adds FILT_CYCLES cycles of
//   latency.
//
// Ports:
//   clk      in   1           fast sampling clock, posedge
//   rst      in   1           asynchronous active-high reset
//   din      in   CHANNELS    asynchronous inputs
//   mode     in   2*CHANNELS  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   clr      in   CHANNELS    synchronous sticky-flag clear strobes
//   dout     out  CHANNELS    registered one-cycle edge pulses
//   level    out  CHANNELS    synchronised (and filtered) input level
//   evt      out  CHANNELS    sticky event flags
//   any_evt  out  1           OR of all evt flags
// -----------------------------------------------------------------------------
module as_edge_detect_multi #(
  parameter int                  CHANNELS    = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] RST_LEVEL   = {CHANNELS{1'b1}},
  parameter int                  FILT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   din,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   dout,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   evt,
  output logic                  any_evt
);

  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_s;
  logic [CHANNELS-1:0] filt_s;
  logic [CHANNELS-1:0] level_r;
  logic [CHANNELS-1:0] hist_r;
  logic [CHANNELS-1:0] rise_s;
  logic [CHANNELS-1:0] fall_s;
  logic [CHANNELS-1:0] mode_rise_s;
  logic [CHANNELS-1:0] mode_fall_s;
  logic [CHANNELS-1:0] dout_r;
  logic [CHANNELS-1:0] evt_r;

  // Synchroniser chain: stage 0 captures din, each later stage follows the previous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < SYNC_STAGES; n++) begin
        sync_r[n] <= RST_LEVEL;
      end
    end else begin
      sync_r[0] <= din;
      for (int n = 1; n < SYNC_STAGES; n++) begin
        sync_r[n] <= sync_r[n-1];
      end
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef AS_EDGE_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);

  logic [3:0]          filt_cnt_r [CHANNELS];
  logic [CHANNELS-1:0] filt_r;

  // Stability filter: a new synchronised level is accepted only after it has
  // disagreed with the held level for FILT_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r <= RST_LEVEL;
      for (int i = 0; i < CHANNELS; i++) begin
        filt_cnt_r[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_s[i] != filt_r[i]) begin
          if (filt_cnt_r[i] == FILT_LAST) begin
            filt_r[i]     <= sync_s[i];
            filt_cnt_r[i] <= 4'd0;
          end else begin
            filt_cnt_r[i] <= filt_cnt_r[i] + 4'd1;
          end
        end else begin
          filt_cnt_r[i] <= 4'd0;
        end
      end
    end
  end

  assign filt_s = filt_r;
`else
  assign filt_s = sync_s;
`endif

  // Split the packed mode bus into per-channel rise and fall enables.
  always_comb begin
    mode_rise_s = {CHANNELS{1'b0}};
    mode_fall_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      mode_rise_s[i] = mode[2*i];
      mode_fall_s[i] = mode[2*i+1];
    end
  end

  // Edges are defined between the current level and the previous cycle's
  // level, so a mode change by itself can never create a pulse.
  assign rise_s = level_r & ~hist_r;
  assign fall_s = ~level_r & hist_r;

  // Level, history, edge pulse and sticky flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= RST_LEVEL;
      hist_r  <= RST_LEVEL;
      dout_r  <= {CHANNELS{1'b0}};
      evt_r   <= {CHANNELS{1'b0}};
    end else begin
      level_r <= filt_s;
      hist_r  <= level_r;
      dout_r  <= (mode_rise_s & rise_s) | (mode_fall_s & fall_s);
      // A set in the same cycle as a clear wins.
      evt_r   <= (evt_r & ~clr) | dout_r;
    end
  end

  assign dout    = dout_r;
  assign level   = level_r;
  assign evt     = evt_r;
  assign any_evt = |evt_r;

endmodule

// File: tb/tb_as_edge_detect_multi.sv
module tb_as_edge_detect_multi;

  localparam int CH = 4;
`ifdef AS_EDGE_GLITCH_FILTER_EN
  localparam int LAT = 4 + 3;
`else
  localparam int LAT = 4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] din;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clr;
  logic [CH-1:0] dout;
  logic [CH-1:0] level;
  logic [CH-1:0] evt;
  logic          any_evt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  as_edge_detect_multi #(
    .CHANNELS(CH),
    .SYNC_STAGES(2),
    .RST_LEVEL(4'hF),
    .FILT_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .mode(mode),
    .clr(clr),
    .dout(dout),
    .level(level),
    .evt(evt),
    .any_evt(any_evt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 4'b0101; mode = 8'hFF; clr = 4'h0;
    step(2);
    total_cnt++; if (dout !== 4'h0) $display("FAIL reset_dout got %h exp %h", dout, 4'h0); else pass_cnt++;
    total_cnt++; if (evt !== 4'h0) $display("FAIL reset_evt got %h exp %h", evt, 4'h0); else pass_cnt++;
    total_cnt++; if (any_evt !== 1'b0) $display("FAIL reset_any got %b exp 0", any_evt); else pass_cnt++;
    total_cnt++; if (level !== 4'hF) $display("FAIL reset_level got %h exp %h", level, 4'hF); else pass_cnt++;
    rst = 1'b0;
    step(LAT-1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL rel_early got %h exp %h", dout, 4'h0); else pass_cnt++;
    total_cnt++; if (level !== 4'b0101) $display("FAIL rel_level got %h exp %h", level, 4'b0101); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'b1010) $display("FAIL rel_pulse got %b exp %b", dout, 4'b1010); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL rel_width got %h exp %h", dout, 4'h0); else pass_cnt++;
    total_cnt++; if (evt !== 4'b1010) $display("FAIL rel_evt got %b exp %b", evt, 4'b1010); else pass_cnt++;
    clr = 4'hF; step(1); clr = 4'h0;
    total_cnt++; if (evt !== 4'h0) $display("FAIL rel_clr got %h exp %h", evt, 4'h0); else pass_cnt++;
  endtask

  task automatic test_rise();
    logic [CH-1:0] seen;
    mode = 8'h01; din = 4'h0;
    step(LAT+2);
    din = 4'b0001;
    step(LAT-1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL rise_early got %h exp %h", dout, 4'h0); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'b0001) $display("FAIL rise_pulse got %b exp %b", dout, 4'b0001); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL rise_width got %h exp %h", dout, 4'h0); else pass_cnt++;
    total_cnt++; if (evt !== 4'b0001 || any_evt !== 1'b1) $display("FAIL rise_evt got %b/%b exp 0001/1", evt, any_evt); else pass_cnt++;
    step(1);
    din = 4'h0;
    seen = 4'h0;
    for (int j = 0; j < LAT+2; j++) begin
      step(1);
      seen |= dout;
    end
    total_cnt++; if (seen !== 4'h0) $display("FAIL rise_nofall got %b exp %b", seen, 4'h0); else pass_cnt++;
    total_cnt++; if (evt !== 4'b0001) $display("FAIL rise_hold got %b exp %b", evt, 4'b0001); else pass_cnt++;
    clr = 4'b0001; step(1); clr = 4'h0;
    total_cnt++; if (evt !== 4'h0 || any_evt !== 1'b0) $display("FAIL rise_clr got %b/%b exp 0000/0", evt, any_evt); else pass_cnt++;
  endtask

  task automatic test_both();
    mode = 8'hFF; din = 4'hF;
    step(LAT-1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL both_early got %h exp %h", dout, 4'h0); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'hF) $display("FAIL both_rise got %h exp %h", dout, 4'hF); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL both_width got %h exp %h", dout, 4'h0); else pass_cnt++;
    total_cnt++; if (evt !== 4'hF) $display("FAIL both_evt got %h exp %h", evt, 4'hF); else pass_cnt++;
    step(2);
    din = 4'h0;
    step(LAT);
    total_cnt++; if (dout !== 4'hF) $display("FAIL both_fall got %h exp %h", dout, 4'hF); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL both_fwidth got %h exp %h", dout, 4'h0); else pass_cnt++;
    step(2);
  endtask

  task automatic test_clear_collision();
    clr = 4'hF; step(1); clr = 4'h0;
    din = 4'hF;
    step(LAT);
    total_cnt++; if (dout !== 4'hF) $display("FAIL coll_pulse got %h exp %h", dout, 4'hF); else pass_cnt++;
    clr = 4'b0100;
    step(1);
    total_cnt++; if (evt !== 4'hF) $display("FAIL coll_setwins got %h exp %h", evt, 4'hF); else pass_cnt++;
    step(1);
    total_cnt++; if (evt !== 4'b1011) $display("FAIL coll_clear got %b exp %b", evt, 4'b1011); else pass_cnt++;
    clr = 4'h0;
    step(2);
  endtask

  task automatic test_mode_off();
    logic [CH-1:0] seen;
    mode = 8'h00; din = 4'b1101;
    seen = 4'h0;
    for (int j = 0; j < LAT; j++) begin step(1); seen |= dout; end
    total_cnt++; if (seen !== 4'h0) $display("FAIL off_fall got %b exp %b", seen, 4'h0); else pass_cnt++;
    total_cnt++; if (level !== 4'b1101) $display("FAIL off_level0 got %b exp %b", level, 4'b1101); else pass_cnt++;
    din = 4'hF;
    seen = 4'h0;
    for (int j = 0; j < LAT; j++) begin step(1); seen |= dout; end
    total_cnt++; if (seen !== 4'h0) $display("FAIL off_rise got %b exp %b", seen, 4'h0); else pass_cnt++;
    total_cnt++; if (level !== 4'hF) $display("FAIL off_level1 got %b exp %b", level, 4'hF); else pass_cnt++;
    mode = 8'h08;
    seen = 4'h0;
    for (int j = 0; j < LAT; j++) begin step(1); seen |= dout; end
    total_cnt++; if (seen !== 4'h0) $display("FAIL sw_nopulse got %b exp %b", seen, 4'h0); else pass_cnt++;
    din = 4'b1101;
    step(LAT-1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL sw_early got %b exp %b", dout, 4'h0); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'b0010) $display("FAIL sw_fall got %b exp %b", dout, 4'b0010); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL sw_width got %b exp %b", dout, 4'h0); else pass_cnt++;
  endtask

`ifdef AS_EDGE_GLITCH_FILTER_EN
  task automatic test_filter();
    logic [CH-1:0] seen;
    logic          lvl_seen;
    mode = 8'h00; din = 4'h0;
    step(LAT+2);
    mode = 8'h01; din = 4'b0001;
    step(2);
    din = 4'h0;
    seen = 4'h0; lvl_seen = 1'b0;
    for (int j = 0; j < LAT+4; j++) begin step(1); seen |= dout; lvl_seen |= level[0]; end
    total_cnt++; if (seen !== 4'h0) $display("FAIL filt_glitch got %b exp %b", seen, 4'h0); else pass_cnt++;
    total_cnt++; if (lvl_seen !== 1'b0) $display("FAIL filt_level got %b exp 0", lvl_seen); else pass_cnt++;
    din = 4'b0001;
    step(5);
    din = 4'h0;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL filt_early got %b exp %b", dout, 4'h0); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'b0001) $display("FAIL filt_pulse got %b exp %b", dout, 4'b0001); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL filt_width got %b exp %b", dout, 4'h0); else pass_cnt++;
    step(LAT+2);
  endtask
`endif

  task automatic test_reset_midpulse();
    mode = 8'hFF; din = 4'hF;
    step(LAT+2);
    din = 4'h0;
    step(LAT);
    total_cnt++; if (dout !== 4'hF) $display("FAIL mid_pulse got %h exp %h", dout, 4'hF); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (dout !== 4'h0 || evt !== 4'h0 || any_evt !== 1'b0) $display("FAIL mid_async got %h/%h/%b exp 0/0/0", dout, evt, any_evt); else pass_cnt++;
    total_cnt++; if (level !== 4'hF) $display("FAIL mid_level got %h exp %h", level, 4'hF); else pass_cnt++;
    step(2);
    rst = 1'b0;
    step(LAT-1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL mid_early got %h exp %h", dout, 4'h0); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'hF) $display("FAIL mid_repulse got %h exp %h", dout, 4'hF); else pass_cnt++;
    step(1);
    total_cnt++; if (dout !== 4'h0) $display("FAIL mid_width got %h exp %h", dout, 4'h0); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; din = 4'b0101; mode = 8'hFF; clr = 4'h0;
    test_reset();
    test_rise();
    test_both();
    test_clear_collision();
    test_mode_off();
`ifdef AS_EDGE_GLITCH_FILTER_EN
    test_filter();
`endif
    test_reset_midpulse();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
